switch_pattern_decoder: RTL and testbench
=========================================

Name: switch_pattern_decoder

Overview:
- Input-side counterpart of the board's LED pattern sequencer: reads the 8 onboard slide switches and debounces each one.
- Produces one-cycle edge pulses per switch.
- Decodes the stable switch vector back into the 4-bit pattern index the LED sequencer uses.
- Reports each change as an event through a valid/ack handshake, so a controller can jump the LED sequence to a chosen step.

Parameters:
- TICK_DIV, 50_000: clocks per debounce sample tick (1 ms at 50 MHz); minimum 2.
- STABLE_COUNT, 8: consecutive differing samples required before a debounced level flips; minimum 2.

Ports:
- Clk_50MHz  in  1  system clock, 50 MHz
- Reset_Onboard  in  1  reset, asynchronous, active-high
- Switch_Input  in  8  raw asynchronous switch levels; bit 7 = leftmost
- Sw_Level  out  8  debounced switch levels
- Sw_Rise  out  8  one-cycle pulse per bit on debounced 0->1
- Sw_Fall  out  8  one-cycle pulse per bit on debounced 1->0
- Pattern_Code  out  4  decoded index of Sw_Level
- Code_Valid  out  1  1 when Sw_Level matches a defined pattern
- Event_Valid  out  1  captured change pending
- Event_Vector  out  8  Sw_Level snapshot at capture
- Event_Code  out  4  Pattern_Code snapshot at capture
- Event_Ack  in  1  consumer accepts pending event
- Event_Overflow  out  1  sticky: a change was dropped while an event was pending
- Overflow_Clear  in  1  clears Event_Overflow

Behaviour:
- Reset (async, high):
  - Synchronizers, counters, Sw_Level, Sw_Rise, Sw_Fall, Event_* all clear to 0.
  - Pattern_Code resets to 8 and Code_Valid to 1, consistent with Sw_Level = 0.
  - Reset asserted mid-debounce or mid-event discards all state; no pulses or events are emitted on release.
- Synchronizer: 2-FF per bit.
- Prescaler: counts 0..TICK_DIV-1 and wraps. Tick is a one-cycle pulse at count TICK_DIV-1.
- Per-bit debounce, evaluated on tick only:
  - If sync != Sw_Level: stability counter increments.
  - When the counter equals STABLE_COUNT-1 and the sample still differs: Sw_Level flips, the counter clears, and the Rise/Fall pulse is asserted in the same cycle as the flip.
  - If sync == Sw_Level: the counter clears, so a glitch restarts qualification.
- Latency, input change to Sw_Level: 2 clocks + STABLE_COUNT ticks (+ up to one tick of phase).
- Switches held high through reset release produce Rise pulses after qualification. This is required; no suppression.
- Decode: registered, one cycle after Sw_Level changes.
  - 1000_0000->0, 0100_0000->1, 0010_0000->2, 0001_0000->3, 0000_1000->4, 0000_0100->5, 0000_0010->6, 0000_0001->7.
  - 0000_0000->8; 1111_1111->9.
  - Anything else ->15 with Code_Valid=0; Code_Valid=1 for all defined patterns.
- Event capture:
  - A change is any nonzero Sw_Rise|Sw_Fall in cycle N.
  - The capture occurs in cycle N+1, so Event_Vector and Event_Code reflect the updated decode.
- Event handshake:
  - Event_Valid=0 at capture: load Vector and Code, set Valid.
  - Event_Valid=1 and Event_Ack=1 in the capture cycle: load the new data, Valid stays 1.
  - Event_Valid=1, Event_Ack=0: keep the old data and set Event_Overflow.
  - Event_Ack with no capture clears Valid the next cycle.
  - Event_Ack while Valid=0 is ignored.
- Overflow_Clear clears Event_Overflow; if a new overflow occurs in the same cycle, set wins.
- Several bits changing on the same tick form one event.

Decomposition:
- Shared package holds:
  - SW_W=8
  - CODE_W=4
  - CODE_ALL_OFF=8, CODE_ALL_ON=9, CODE_INVALID=15
  - the one-hot/index mapping constants, also used by the LED sequencer
- Sub-module: switch_debounce_bit, instantiated 8 times. It contains the synchronizer, stability counter, level, rise and fall. The prescaler tick is shared from the top.

Test Plan (TICK_DIV=4, STABLE_COUNT=3):
- Reset with Switch_Input=0 -> Sw_Level=0, Pattern_Code=8, Code_Valid=1, Event_Valid=0 and no pulses for 100 clocks.
- Switch_Input 0x00->0x20, held -> Sw_Level=0x20 within 2+3 ticks (+1 tick), Sw_Rise=0x20 for exactly 1 cycle, next cycle Pattern_Code=2, Event_Valid=1, Event_Vector=0x20, Event_Code=2.
- Bit 0 toggles every 3 clocks for 40 clocks, then settles at 0 -> Sw_Level bit 0 never changes, no pulses, no event.
- Switch_Input set to 0xFF, then 0x81 -> codes 9, then 15 with Code_Valid=0, and corresponding events.
- Event pending (Event_Ack=0) while a second change 0x20->0x00 qualifies -> Event_Vector stays 0x20 and Event_Overflow=1. Overflow_Clear pulse -> 0. Ack coincident with a third capture -> new data loaded, Valid held at 1.
- Reset asserted 2 ticks into qualifying 0x01 -> after release no Rise pulse until a full 3-tick requalification; Sw_Level then = 0x01, code 7.

Source files
------------

// File: rtl/switch_pattern_decoder_pkg.sv
// Shared switch/LED pattern constants: vector widths, special codes and the
// step-index <-> one-hot mapping used by both the LED sequencer and this decoder.
package switch_pattern_decoder_pkg;

   localparam int SW_W      = 8;
   localparam int CODE_W    = 4;
   localparam int NUM_STEPS = 8;

   localparam logic [CODE_W-1:0] CODE_ALL_OFF = 4'd8;
   localparam logic [CODE_W-1:0] CODE_ALL_ON  = 4'd9;
   localparam logic [CODE_W-1:0] CODE_INVALID = 4'd15;

   // Step 0 lights the leftmost LED (bit 7); element 0 is the rightmost entry.
   localparam logic [NUM_STEPS-1:0][SW_W-1:0] STEP_PATTERN = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
   };

   function automatic logic [SW_W-1:0] step_pattern(input logic [CODE_W-1:0] step);
      logic [SW_W-1:0] pat;
      pat = '0;
      for (int i = 0; i < NUM_STEPS; i++) begin
         if (step == CODE_W'(i)) pat = STEP_PATTERN[i];
      end
      return pat;
   endfunction

   function automatic logic [CODE_W-1:0] decode_pattern(input logic [SW_W-1:0] level);
      logic [CODE_W-1:0] code;
      code = CODE_INVALID;
      if (level == '0) begin
         code = CODE_ALL_OFF;
      end else if (level == '1) begin
         code = CODE_ALL_ON;
      end else begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            if (level == STEP_PATTERN[i]) code = CODE_W'(i);
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch: 2-FF synchronizer, tick-qualified stability counter, debounced
// level with single-cycle rise/fall pulses registered alongside the flip.
module switch_debounce_bit #(
   parameter int STABLE_COUNT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(STABLE_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         if (tick) begin
            // Any agreeing sample restarts qualification, so glitches never accumulate.
            if (sync_p1 != level) begin
               if (cnt == CNT_LAST) begin
                  level <= ~level;
                  cnt   <= '0;
                  rise  <= ~level;
                  fall  <= level;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end else begin
               cnt <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/switch_pattern_decoder.sv
// Debounces the 8 slide switches, decodes the stable vector to an LED step
// index and reports each change as a valid/ack event with sticky overflow.
module switch_pattern_decoder
   import switch_pattern_decoder_pkg::*;
#(
   parameter int TICK_DIV     = 50_000,
   parameter int STABLE_COUNT = 8
) (
   input  logic              Clk_50MHz,
   input  logic              Reset_Onboard,
   input  logic [SW_W-1:0]   Switch_Input,
   output logic [SW_W-1:0]   Sw_Level,
   output logic [SW_W-1:0]   Sw_Rise,
   output logic [SW_W-1:0]   Sw_Fall,
   output logic [CODE_W-1:0] Pattern_Code,
   output logic              Code_Valid,
   output logic              Event_Valid,
   output logic [SW_W-1:0]   Event_Vector,
   output logic [CODE_W-1:0] Event_Code,
   input  logic              Event_Ack,
   output logic              Event_Overflow,
   input  logic              Overflow_Clear
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]  pre_cnt;
   logic              tick;
   logic              capture;
   logic [CODE_W-1:0] decode_next;

   always_ff @(posedge Clk_50MHz or posedge Reset_Onboard) begin
      if (Reset_Onboard) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   assign tick = (pre_cnt == PRE_LAST);

   for (genvar i = 0; i < SW_W; i++) begin : g_bit
      switch_debounce_bit #(
         .STABLE_COUNT(STABLE_COUNT)
      ) u_debounce (
         .clk  (Clk_50MHz),
         .rst  (Reset_Onboard),
         .tick (tick),
         .raw  (Switch_Input[i]),
         .level(Sw_Level[i]),
         .rise (Sw_Rise[i]),
         .fall (Sw_Fall[i])
      );
   end

   assign decode_next = decode_pattern(Sw_Level);
   assign capture     = |(Sw_Rise | Sw_Fall);

   // Decode stage: follows Sw_Level by one clock.
   always_ff @(posedge Clk_50MHz or posedge Reset_Onboard) begin
      if (Reset_Onboard) begin
         Pattern_Code <= CODE_ALL_OFF;
         Code_Valid   <= 1'b1;
      end else begin
         Pattern_Code <= decode_next;
         Code_Valid   <= (decode_next != CODE_INVALID);
      end
   end

   // Event stage: snapshot taken on the edge that also registers the decode.
   always_ff @(posedge Clk_50MHz or posedge Reset_Onboard) begin
      if (Reset_Onboard) begin
         Event_Valid    <= 1'b0;
         Event_Vector   <= '0;
         Event_Code     <= '0;
         Event_Overflow <= 1'b0;
      end else begin
         if (capture) begin
            if (!Event_Valid || Event_Ack) begin
               Event_Vector <= Sw_Level;
               Event_Code   <= decode_next;
               Event_Valid  <= 1'b1;
            end
         end else if (Event_Valid && Event_Ack) begin
            Event_Valid <= 1'b0;
         end
         // A fresh drop beats a simultaneous clear.
         if (capture && Event_Valid && !Event_Ack) begin
            Event_Overflow <= 1'b1;
         end else if (Overflow_Clear) begin
            Event_Overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_switch_pattern_decoder.sv
// Scoreboard bench: stimulus pushes expected debounce/event results, a monitor
// pops and checks them whenever the DUT emits an edge pulse.
module tb_switch_pattern_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic [7:0] level, rise, fall, ev_vec;
   logic [3:0] code, ev_code;
   logic       cv, ev_valid, ack, ovf, ovf_clr;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] level;
      logic [3:0] code;
      logic       cv;
      logic [7:0] ev_vec;
      logic [3:0] ev_code;
   } exp_t;

   exp_t q[$];

   switch_pattern_decoder #(
      .TICK_DIV    (4),
      .STABLE_COUNT(3)
   ) dut (
      .Clk_50MHz     (clk),
      .Reset_Onboard (rst),
      .Switch_Input  (sw),
      .Sw_Level      (level),
      .Sw_Rise       (rise),
      .Sw_Fall       (fall),
      .Pattern_Code  (code),
      .Code_Valid    (cv),
      .Event_Valid   (ev_valid),
      .Event_Vector  (ev_vec),
      .Event_Code    (ev_code),
      .Event_Ack     (ack),
      .Event_Overflow(ovf),
      .Overflow_Clear(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] r, input logic [7:0] f, input logic [7:0] l,
                       input logic [3:0] c, input logic v, input logic [7:0] evv,
                       input logic [3:0] evc);
      exp_t e;
      e.rise = r; e.fall = f; e.level = l; e.code = c; e.cv = v;
      e.ev_vec = evv; e.ev_code = evc;
      q.push_back(e);
   endtask

   task automatic drain(input string name);
      int i;
      for (i = 0; i < 80; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timeout, %0d expected pulses still pending", name, q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic ack_pulse(input string name);
      @(negedge clk) ack = 1'b1;
      @(negedge clk) ack = 1'b0;
      check(name, ev_valid, 0);
   endtask

   // Monitor: every edge pulse must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1 && (rise | fall) != 8'h00) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: got rise=0x%0h fall=0x%0h, expected none", rise, fall);
            end else begin
               e = q.pop_front();
               check("rise", rise, e.rise);
               check("fall", fall, e.fall);
               check("level", level, e.level);
               @(negedge clk);
               check("rise_width", rise, 0);
               check("fall_width", fall, 0);
               check("pattern_code", code, e.code);
               check("code_valid", cv, e.cv);
               check("event_valid", ev_valid, 1);
               check("event_vector", ev_vec, e.ev_vec);
               check("event_code", ev_code, e.ev_code);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; sw = 8'h00; ack = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_level", level, 8'h00);
      check("rst_code", code, 4'd8);
      check("rst_cv", cv, 1);
      check("rst_ev_valid", ev_valid, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("idle_level", level, 8'h00);
      check("idle_ev_valid", ev_valid, 0);

      // Single switch -> step 2
      push(8'h20, 8'h00, 8'h20, 4'd2, 1'b1, 8'h20, 4'd2);
      sw = 8'h20;
      drain("sw_20");
      ack_pulse("ack_20");
      ack_pulse("ack_idle_ignored");
      check("ovf_after_idle_ack", ovf, 0);

      // Bit 0 bouncing never holds for 3 consecutive ticks
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i % 3 == 0) sw[0] = ~sw[0];
      end
      sw = 8'h20;
      repeat (30) @(negedge clk);
      check("bounce_level", level, 8'h20);
      check("bounce_ev_valid", ev_valid, 0);

      push(8'hDF, 8'h00, 8'hFF, 4'd9, 1'b1, 8'hFF, 4'd9);
      sw = 8'hFF;
      drain("sw_ff");
      ack_pulse("ack_ff");

      push(8'h00, 8'h7E, 8'h81, 4'd15, 1'b0, 8'h81, 4'd15);
      sw = 8'h81;
      drain("sw_81");
      ack_pulse("ack_81");

      // Leave the 0x20 event pending so the next change overflows
      push(8'h20, 8'h81, 8'h20, 4'd2, 1'b1, 8'h20, 4'd2);
      sw = 8'h20;
      drain("sw_20b");
      push(8'h00, 8'h20, 8'h00, 4'd8, 1'b1, 8'h20, 4'd2);
      sw = 8'h00;
      drain("sw_00_overflow");
      check("ovf_set", ovf, 1);
      check("ovf_vec_kept", ev_vec, 8'h20);
      @(negedge clk) ovf_clr = 1'b1;
      @(negedge clk) ovf_clr = 1'b0;
      check("ovf_cleared", ovf, 0);

      // Ack lands on the same edge as the third capture
      push(8'h01, 8'h00, 8'h01, 4'd7, 1'b1, 8'h01, 4'd7);
      sw = 8'h01;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if ((rise | fall) != 8'h00) break;
      end
      ack = 1'b1;
      @(negedge clk) ack = 1'b0;
      drain("sw_01_ack_capture");
      check("ack_capture_valid_held", ev_valid, 1);
      check("ack_capture_no_ovf", ovf, 0);
      ack_pulse("ack_01");

      // Reset part-way through qualifying 0x01
      @(negedge clk) begin rst = 1'b1; sw = 8'h00; end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      sw = 8'h01;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midq_rst_level", level, 8'h00);
      check("midq_rst_ev_valid", ev_valid, 0);
      push(8'h01, 8'h00, 8'h01, 4'd7, 1'b1, 8'h01, 4'd7);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if ((rise | fall) != 8'h00) break;
      end
      check("requal_latency", n, 12);
      drain("requal_01");
      check("requal_level", level, 8'h01);
      check("requal_code", code, 4'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
